// File: rtl/imem_arbiter_pkg.sv
// Shared types and default constants for the instruction-memory arbiter.
package imem_arbiter_pkg;

    // IMem byte-address width and instruction/data word width.
    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;

    // Max consecutive loader grants while a fetch is waiting.
    localparam int LOAD_BURST_MAX = 4;

    // Owner of the previous cycle's IMem access.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2
    } imem_arb_state_e;

    // Bits needed to hold a count from 0 up to and including max_count.
    function automatic int burst_cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Request/grant and IMem bus bundle between the fetch stage, the program
// loader and the arbiter. The arbiter takes the slave view; the requesters
// (and whatever observes the memory side) take the master view.
interface imem_arbiter_if
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = imem_arbiter_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = imem_arbiter_pkg::DATA_WIDTH
);
    // Fetch side
    logic                  fetchReq;
    logic [ADDR_WIDTH-1:0] fetchAddr;
    logic                  fetchFlush;
    logic                  fetchGrant;
    logic                  fetchValid;
    logic                  fetchStall;

    // Loader side
    logic                  loadReq;
    logic [ADDR_WIDTH-1:0] loadAddr;
    logic [DATA_WIDTH-1:0] loadData;
    logic                  loadGrant;

    // IMem side
    logic                  memEn;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWdata;

    modport slave (
        input  fetchReq, fetchAddr, fetchFlush,
        input  loadReq, loadAddr, loadData,
        output fetchGrant, fetchValid, fetchStall,
        output loadGrant,
        output memEn, memWe, memAddr, memWdata
    );

    modport master (
        output fetchReq, fetchAddr, fetchFlush,
        output loadReq, loadAddr, loadData,
        input  fetchGrant, fetchValid, fetchStall,
        input  loadGrant,
        input  memEn, memWe, memAddr, memWdata
    );

endinterface

// File: rtl/imem_arbiter_burst_counter.sv
// Saturating count of consecutive loader grants taken while fetch waits.
// Clear has priority over increment; sat flags that fetch must win next.
module imem_arbiter_burst_counter
    import imem_arbiter_pkg::*;
#(
    parameter int MAX_COUNT = LOAD_BURST_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic sat
);
    localparam int                CW      = burst_cnt_width(MAX_COUNT);
    localparam logic [CW-1:0]     MAX_VAL = CW'(MAX_COUNT);

    logic [CW-1:0] count;

    // Count loader grants, holding at MAX_VAL until cleared.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count == MAX_VAL);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port IMem arbiter between the fetch stage (reads) and the program
// loader (writes). The loader normally wins, but after LOAD_BURST_MAX
// back-to-back loader grants against a waiting fetch, fetch gets one slot.
// The IMem read is synchronous, so read data for a fetch granted this cycle
// is valid next cycle; the FSM state (owner of the previous access) doubles
// as that registered fetch grant.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = imem_arbiter_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = imem_arbiter_pkg::DATA_WIDTH,
    parameter int LOAD_BURST_MAX = imem_arbiter_pkg::LOAD_BURST_MAX
) (
    input  logic          clk,
    input  logic          rst,
    imem_arbiter_if.slave bus
);
    imem_arb_state_e       state;
    imem_arb_state_e       state_next;

    logic                  fetch_grant;
    logic                  load_grant;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  burst_clr;
    logic                  burst_inc;
    logic                  burst_sat;

    imem_arbiter_burst_counter #(
        .MAX_COUNT (LOAD_BURST_MAX)
    ) u_burst (
        .clk (clk),
        .rst (rst),
        .clr (burst_clr),
        .inc (burst_inc),
        .sat (burst_sat)
    );

    // Record who owned this cycle's IMem access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Same-cycle grant decision, IMem drive and next owner.
    // NOTE: every output gets a default before any branch so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next  = IDLE;
        fetch_grant = 1'b0;
        load_grant  = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        burst_clr   = 1'b1;
        burst_inc   = 1'b0;

        if (rst) begin
            if (bus.loadReq && !(bus.fetchReq && burst_sat)) begin
                load_grant = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = bus.loadAddr;
                mem_wdata  = bus.loadData;
                state_next = LOAD;
            end else if (bus.fetchReq) begin
                fetch_grant = 1'b1;
                mem_addr    = bus.fetchAddr;
                state_next  = FETCH;
            end
            // Only a loader grant against a waiting fetch extends the burst.
            burst_inc = load_grant && bus.fetchReq;
            burst_clr = fetch_grant || !bus.fetchReq;
        end
    end

    assign bus.fetchGrant = fetch_grant;
    assign bus.loadGrant  = load_grant;
    assign bus.memEn      = fetch_grant | load_grant;
    assign bus.memWe      = mem_we;
    assign bus.memAddr    = mem_addr;
    assign bus.memWdata   = mem_wdata;
    assign bus.fetchStall = bus.fetchReq & ~fetch_grant;

    // A flush kills the read returning this cycle (granted last cycle); a
    // fetch granted alongside the flush is the redirected one and survives.
    assign bus.fetchValid = (state == FETCH) & ~bus.fetchFlush;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: a reference model predicts each
// cycle's outputs into a scoreboard queue, popped and compared mid-cycle.
module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    localparam int BURST = 4;

    typedef struct {
        logic        fg;
        logic        lg;
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        valid;
    } exp_t;

    logic clk;
    logic rst;

    imem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    imem_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .LOAD_BURST_MAX (BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    int       cyc    = 0;
    exp_t     sb[$];
    int       m_cnt        = 0;
    logic     m_prev_fetch = 1'b0;
    logic [9:0] grant_hist = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's requests (called at posedge+1), predict, compare at
    // negedge, then advance the model and step to the next posedge+1.
    task automatic drive_cycle(input logic fr, input logic [31:0] fa, input logic ff,
                               input logic lr, input logic [31:0] la, input logic [31:0] ld);
        exp_t e;
        exp_t x;
        bus.fetchReq   = fr;
        bus.fetchAddr  = fa;
        bus.fetchFlush = ff;
        bus.loadReq    = lr;
        bus.loadAddr   = la;
        bus.loadData   = ld;

        e.lg    = lr && !(fr && (m_cnt == BURST));
        e.fg    = fr && !e.lg;
        e.en    = e.lg || e.fg;
        e.we    = e.lg;
        e.addr  = e.lg ? la : (e.fg ? fa : 32'h0);
        e.wdata = e.lg ? ld : 32'h0;
        e.stall = fr && !e.fg;
        e.valid = m_prev_fetch && !ff;
        sb.push_back(e);

        @(negedge clk);
        x = sb.pop_front();
        check($sformatf("c%0d.fetchGrant", cyc), 64'(bus.fetchGrant), 64'(x.fg));
        check($sformatf("c%0d.loadGrant",  cyc), 64'(bus.loadGrant),  64'(x.lg));
        check($sformatf("c%0d.memEn",      cyc), 64'(bus.memEn),      64'(x.en));
        check($sformatf("c%0d.memWe",      cyc), 64'(bus.memWe),      64'(x.we));
        check($sformatf("c%0d.memAddr",    cyc), 64'(bus.memAddr),    64'(x.addr));
        check($sformatf("c%0d.memWdata",   cyc), 64'(bus.memWdata),   64'(x.wdata));
        check($sformatf("c%0d.fetchStall", cyc), 64'(bus.fetchStall), 64'(x.stall));
        check($sformatf("c%0d.fetchValid", cyc), 64'(bus.fetchValid), 64'(x.valid));
        grant_hist = {grant_hist[8:0], bus.loadGrant};

        m_prev_fetch = e.fg;
        if (e.fg || !fr)                  m_cnt = 0;
        else if (e.lg && (m_cnt < BURST)) m_cnt++;
        cyc++;

        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Hard stop in case anything ever blocks.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        bus.fetchReq   = 1'b1;
        bus.fetchAddr  = 32'h40;
        bus.fetchFlush = 1'b0;
        bus.loadReq    = 1'b1;
        bus.loadAddr   = 32'h80;
        bus.loadData   = 32'h1234_5678;

        // Reset state, with both requests asserted.
        #3;
        check("rst.memEn",      64'(bus.memEn),      64'd0);
        check("rst.fetchGrant", 64'(bus.fetchGrant), 64'd0);
        check("rst.loadGrant",  64'(bus.loadGrant),  64'd0);
        check("rst.memWe",      64'(bus.memWe),      64'd0);
        check("rst.memAddr",    64'(bus.memAddr),    64'd0);
        check("rst.memWdata",   64'(bus.memWdata),   64'd0);
        check("rst.fetchValid", 64'(bus.fetchValid), 64'd0);
        check("rst.state",      64'(dut.state),      64'(IDLE));
        @(posedge clk);
        #1;
        check("rst_edge.memEn", 64'(bus.memEn),      64'd0);
        check("rst_edge.count", 64'(dut.u_burst.count), 64'd0);
        rst = 1'b1;

        // Continuous fetch 0x0, 0x4, 0x8, then one idle cycle for last data.
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0);
        idle_cycle();

        // Both requesting for 10 cycles: L,L,L,L,F repeated.
        grant_hist = '0;
        for (int i = 0; i < 10; i++)
            drive_cycle(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b1, 32'h300 + 32'(i * 4), 32'hA000 + 32'(i));
        check("burst_pattern", 64'(grant_hist), 64'(10'b1111011110));
        idle_cycle();

        // Flush one cycle after a grant, with a redirected fetch alongside it.
        drive_cycle(1'b1, 32'h10,  1'b0, 1'b0, 32'h0, 32'h0);
        drive_cycle(1'b1, 32'h500, 1'b1, 1'b0, 32'h0, 32'h0);
        idle_cycle();

        // Loader write only.
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
        idle_cycle();

        // No requests: everything quiet, state back to IDLE.
        idle_cycle();
        check("idle.state", 64'(dut.state), 64'(IDLE));

        // Reset asserted in the middle of the third loader grant.
        drive_cycle(1'b1, 32'h600, 1'b0, 1'b1, 32'h700, 32'h1);
        drive_cycle(1'b1, 32'h604, 1'b0, 1'b1, 32'h704, 32'h2);
        bus.loadAddr = 32'h708;
        bus.loadData = 32'h3;
        #1;
        check("pre_rst.loadGrant", 64'(bus.loadGrant), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_rst.loadGrant",  64'(bus.loadGrant),  64'd0);
        check("mid_rst.memEn",      64'(bus.memEn),      64'd0);
        check("mid_rst.memWe",      64'(bus.memWe),      64'd0);
        check("mid_rst.fetchValid", 64'(bus.fetchValid), 64'd0);
        check("mid_rst.count",      64'(dut.u_burst.count), 64'd0);
        check("mid_rst.state",      64'(dut.state),      64'(IDLE));
        #1;
        rst          = 1'b1;
        m_cnt        = 0;
        m_prev_fetch = 1'b0;
        drive_cycle(1'b1, 32'h608, 1'b0, 1'b1, 32'h708, 32'h3);
        check("post_rst.count", 64'(dut.u_burst.count), 64'd1);

        // Mixed random traffic against the model.
        for (int i = 0; i < 40; i++)
            drive_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0),
                        1'($urandom_range(0, 1)), $urandom, $urandom);
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
